// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer_pkg / cpu_sequencer_if
// Description : Shared types and the handshake bundle between the CPU control
//               sequencer and the decode unit, datapath, memory and rasterizer.
//   Inputs to the sequencer (master modport):
//     inst_type, inst_subtype   registered instruction type / subtype
//     core_special_op           registered special op (NOP/HALT/RESET)
//     gpu_submit                current instruction is a rasterizer command
//     gpu_busy                  rasterizer busy
//     resume                    leave HALT (level)
//   Outputs of the sequencer (master modport):
//     inst_latch_en, decode_en, mem_access, mem_data_phase, pc_inc,
//     rf_write_en, gpu_submit_strobe, soft_reset, halted
// Revision    : 1.0 - initial release
// ============================================================================

package cpu_sequencer_pkg;
  typedef enum logic [1:0] {
    CORE_NOP   = 2'd0,
    CORE_HALT  = 2'd1,
    CORE_RESET = 2'd2
  } core_special_operation_t;
endpackage

interface cpu_sequencer_if;
  import cpu_sequencer_pkg::*;

  logic [1:0]             inst_type;
  logic [2:0]             inst_subtype;
  core_special_operation_t core_special_op;
  logic                   gpu_submit;
  logic                   gpu_busy;
  logic                   resume;

  logic                   inst_latch_en;
  logic                   decode_en;
  logic                   mem_access;
  logic                   mem_data_phase;
  logic                   pc_inc;
  logic                   rf_write_en;
  logic                   gpu_submit_strobe;
  logic                   soft_reset;
  logic                   halted;

  // Sequencer side
  modport master (
    input  inst_type, inst_subtype, core_special_op, gpu_submit, gpu_busy, resume,
    output inst_latch_en, decode_en, mem_access, mem_data_phase, pc_inc,
           rf_write_en, gpu_submit_strobe, soft_reset, halted
  );

  // Decode / datapath / memory / rasterizer side
  modport slave (
    output inst_type, inst_subtype, core_special_op, gpu_submit, gpu_busy, resume,
    input  inst_latch_en, decode_en, mem_access, mem_data_phase, pc_inc,
           rf_write_en, gpu_submit_strobe, soft_reset, halted
  );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle control sequencer. Steps each instruction through
//               FETCH (MEM_LATENCY cycles), DECODE (1), EXECUTE (1) and the
//               optional MEM_WAIT / GPU_WAIT phases, plus a HALT state.
//   Ports:
//     clk        core clock
//     rst_async  asynchronous active-high reset (state -> BOOT, counter -> 0)
//     bus        cpu_sequencer_if.master: decode inputs, control strobes out
//   Parameter:
//     MEM_LATENCY  cycles per memory access, 1..15
//   All outputs are decoded combinationally from state, counter and inputs.
// Revision    : 1.0 - initial release
// ============================================================================

module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  wire logic       clk,
  input  wire logic       rst_async,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXECUTE  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_GPU_WAIT = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  // Counter value on the final cycle of a memory access
  localparam logic [3:0] c_last_cnt = 4'(MEM_LATENCY - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;

  logic w_inst_latch_en;
  logic w_decode_en;
  logic w_mem_access;
  logic w_mem_data_phase;
  logic w_pc_inc;
  logic w_rf_write_en;
  logic w_gpu_submit_strobe;
  logic w_soft_reset;
  logic w_halted;

  // Subtype does not affect sequencing (type 01 writes back for any subtype)
  logic w_unused_subtype;
  assign w_unused_subtype = ^bus.inst_subtype;

  // --------------------------------------------------------------------------
  // State and latency counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= S_BOOT;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state        = r_state;
    w_next_cnt          = r_cnt;
    w_inst_latch_en     = 1'b0;
    w_decode_en         = 1'b0;
    w_mem_access        = 1'b0;
    w_mem_data_phase    = 1'b0;
    w_pc_inc            = 1'b0;
    w_rf_write_en       = 1'b0;
    w_gpu_submit_strobe = 1'b0;
    w_soft_reset        = 1'b0;
    w_halted            = 1'b0;

    unique case (r_state)
      S_BOOT: begin
        w_next_state = S_FETCH;
        w_next_cnt   = 4'd0;
      end

      S_FETCH: begin
        w_mem_access = 1'b1;
        if (r_cnt == c_last_cnt) begin
          w_inst_latch_en = 1'b1;
          w_next_cnt      = 4'd0;
          w_next_state    = S_DECODE;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_DECODE: begin
        w_decode_en  = 1'b1;
        w_next_state = S_EXECUTE;
      end

      S_EXECUTE: begin
        // Unlisted special-op encodings fall through as NOP
        if (bus.core_special_op == CORE_RESET) begin
          w_soft_reset = 1'b1;
          w_next_state = S_FETCH;
        end else if (bus.core_special_op == CORE_HALT) begin
          w_pc_inc     = 1'b1;
          w_next_state = S_HALT;
        end else if (bus.gpu_submit) begin
          if (!bus.gpu_busy) begin
            w_gpu_submit_strobe = 1'b1;
            w_pc_inc            = 1'b1;
            w_next_state        = S_FETCH;
          end else begin
            w_next_state = S_GPU_WAIT;
          end
        end else if (bus.inst_type == 2'b10) begin
          w_next_cnt   = 4'd0;
          w_next_state = S_MEM_WAIT;
        end else if (bus.inst_type[0]) begin
          // Types 01 and 11 write back a result
          w_rf_write_en = 1'b1;
          w_pc_inc      = 1'b1;
          w_next_state  = S_FETCH;
        end else begin
          w_pc_inc     = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      S_MEM_WAIT: begin
        w_mem_access     = 1'b1;
        w_mem_data_phase = 1'b1;
        if (r_cnt == c_last_cnt) begin
          w_rf_write_en = 1'b1;
          w_pc_inc      = 1'b1;
          w_next_cnt    = 4'd0;
          w_next_state  = S_FETCH;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_GPU_WAIT: begin
        // Strobe is issued only on leaving, so one submit per instruction
        if (!bus.gpu_busy) begin
          w_gpu_submit_strobe = 1'b1;
          w_pc_inc            = 1'b1;
          w_next_state        = S_FETCH;
        end
      end

      S_HALT: begin
        w_halted = 1'b1;
        if (bus.resume) begin
          w_next_cnt   = 4'd0;
          w_next_state = S_FETCH;
        end
      end

      default: begin
        w_next_state = S_BOOT;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  assign bus.inst_latch_en     = w_inst_latch_en;
  assign bus.decode_en         = w_decode_en;
  assign bus.mem_access        = w_mem_access;
  assign bus.mem_data_phase    = w_mem_data_phase;
  assign bus.pc_inc            = w_pc_inc;
  assign bus.rf_write_en       = w_rf_write_en;
  assign bus.gpu_submit_strobe = w_gpu_submit_strobe;
  assign bus.soft_reset        = w_soft_reset;
  assign bus.halted            = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. DUT A uses
//               MEM_LATENCY=3 and runs directed plus random instructions; DUT B
//               uses MEM_LATENCY=1 and runs a repeating ADD. Expected outputs
//               are built per instruction from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  // Expected-vector bit masks
  localparam logic [8:0] M_LATCH = 9'h100;
  localparam logic [8:0] M_DEC   = 9'h080;
  localparam logic [8:0] M_MEM   = 9'h040;
  localparam logic [8:0] M_DPH   = 9'h020;
  localparam logic [8:0] M_PC    = 9'h010;
  localparam logic [8:0] M_RF    = 9'h008;
  localparam logic [8:0] M_GS    = 9'h004;
  localparam logic [8:0] M_SR    = 9'h002;
  localparam logic [8:0] M_HLT   = 9'h001;
  localparam logic [8:0] M_NONE  = 9'h000;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  cpu_sequencer_if seq_a ();
  cpu_sequencer_if seq_b ();

  cpu_sequencer #(.MEM_LATENCY(LAT_A)) u_dut_a (
    .clk       (clk),
    .rst_async (rst_a),
    .bus       (seq_a)
  );

  cpu_sequencer #(.MEM_LATENCY(LAT_B)) u_dut_b (
    .clk       (clk),
    .rst_async (rst_b),
    .bus       (seq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one DUT's outputs at the falling edge, then move past the next
  // rising edge so the caller can drive the following cycle's inputs.
  task automatic cyc(input logic [8:0] exp, input bit use_b, input string tag);
    logic [8:0] obs;
    @(negedge clk);
    if (use_b)
      obs = {seq_b.inst_latch_en, seq_b.decode_en, seq_b.mem_access, seq_b.mem_data_phase,
             seq_b.pc_inc, seq_b.rf_write_en, seq_b.gpu_submit_strobe, seq_b.soft_reset,
             seq_b.halted};
    else
      obs = {seq_a.inst_latch_en, seq_a.decode_en, seq_a.mem_access, seq_a.mem_data_phase,
             seq_a.pc_inc, seq_a.rf_write_en, seq_a.gpu_submit_strobe, seq_a.soft_reset,
             seq_a.halted};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (latch,dec,mem,dph,pc,rf,gs,sr,hlt)",
             tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Random values on every decode input; the sequencer must ignore them
  // outside the states that sample them.
  task automatic scramble();
    seq_a.inst_type       = 2'($urandom);
    seq_a.inst_subtype    = 3'($urandom);
    seq_a.core_special_op = core_special_operation_t'(2'($urandom));
    seq_a.gpu_submit      = 1'($urandom);
    seq_a.gpu_busy        = 1'($urandom);
    seq_a.resume          = 1'($urandom);
  endtask

  // One complete instruction on DUT A. wait_n is the number of busy GPU_WAIT
  // cycles or resume-low HALT cycles. abort_mem >= 0 asserts reset during that
  // MEM_WAIT cycle index and returns early.
  task automatic do_instr(input logic [1:0] op, input logic gpu, input logic busy,
                          input logic [1:0] typ, input logic [2:0] sub,
                          input int wait_n, input int abort_mem, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < LAT_A; i++) begin
      scramble();
      cyc((i == LAT_A - 1) ? (M_MEM | M_LATCH) : M_MEM, 1'b0, "fetch");
    end
    scramble();
    cyc(M_DEC, 1'b0, "decode");

    seq_a.core_special_op = core_special_operation_t'(op);
    seq_a.gpu_submit      = gpu;
    seq_a.gpu_busy        = busy;
    seq_a.inst_type       = typ;
    seq_a.inst_subtype    = sub;
    seq_a.resume          = 1'($urandom);

    if (op == 2'd2) begin
      cyc(M_SR, 1'b0, "exec_reset");
    end else if (op == 2'd1) begin
      cyc(M_PC, 1'b0, "exec_halt");
      for (int w = 0; w < wait_n; w++) begin
        seq_a.resume = 1'b0;
        cyc(M_HLT, 1'b0, "halt_hold");
      end
      seq_a.resume = 1'b1;
      cyc(M_HLT, 1'b0, "halt_exit");
    end else if (gpu) begin
      if (!busy) begin
        cyc(M_GS | M_PC, 1'b0, "exec_gpu_free");
      end else begin
        cyc(M_NONE, 1'b0, "exec_gpu_busy");
        for (int w = 0; w < wait_n; w++) begin
          seq_a.gpu_busy = 1'b1;
          cyc(M_NONE, 1'b0, "gpu_wait");
        end
        seq_a.gpu_busy = 1'b0;
        cyc(M_GS | M_PC, 1'b0, "gpu_release");
      end
    end else if (typ == 2'b10) begin
      cyc(M_NONE, 1'b0, "exec_mem");
      for (int i = 0; i < LAT_A; i++) begin
        if (i == abort_mem) begin
          rst_a = 1'b1;
          cyc(M_NONE, 1'b0, "mid_reset");
          aborted = 1'b1;
          return;
        end
        scramble();
        cyc((i == LAT_A - 1) ? (M_MEM | M_DPH | M_RF | M_PC) : (M_MEM | M_DPH),
            1'b0, "mem_wait");
      end
    end else if (typ == 2'b01 || typ == 2'b11) begin
      cyc(M_RF | M_PC, 1'b0, "exec_alu");
    end else begin
      cyc(M_PC, 1'b0, "exec_nop");
    end
  endtask

  initial begin
    bit         ab;
    logic [1:0] op;
    int         r;

    checks = 0;
    errors = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    scramble();
    seq_b.inst_type       = 2'b01;
    seq_b.inst_subtype    = 3'b010;
    seq_b.core_special_op = CORE_NOP;
    seq_b.gpu_submit      = 1'b0;
    seq_b.gpu_busy        = 1'b0;
    seq_b.resume          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    cyc(M_NONE, 1'b0, "reset_a");
    cyc(M_NONE, 1'b1, "reset_b");

    // DUT B: ADD repeating with period 3 at MEM_LATENCY=1
    rst_b = 1'b0;
    cyc(M_NONE, 1'b1, "b_boot");
    for (int k = 0; k < 3; k++) begin
      cyc(M_MEM | M_LATCH, 1'b1, "b_fetch");
      cyc(M_DEC, 1'b1, "b_decode");
      cyc(M_RF | M_PC, 1'b1, "b_exec_add");
    end
    rst_b = 1'b1;

    // DUT A directed
    rst_a = 1'b0;
    cyc(M_NONE, 1'b0, "a_boot");
    do_instr(2'd0, 1'b0, 1'b0, 2'b01, 3'b010, 0, -1, ab);  // ADD
    do_instr(2'd0, 1'b0, 1'b0, 2'b10, 3'b000, 0, -1, ab);  // data memory
    do_instr(2'd0, 1'b1, 1'b1, 2'b00, 3'b000, 4, -1, ab);  // busy 5 cycles
    do_instr(2'd0, 1'b1, 1'b0, 2'b11, 3'b000, 0, -1, ab);  // GPU free
    do_instr(2'd1, 1'b0, 1'b0, 2'b00, 3'b000, 10, -1, ab); // HALT 11 cycles
    do_instr(2'd2, 1'b1, 1'b0, 2'b01, 3'b000, 0, -1, ab);  // RESET beats GPU
    do_instr(2'd3, 1'b0, 1'b0, 2'b11, 3'b000, 0, -1, ab);  // unlisted op = NOP
    do_instr(2'd0, 1'b0, 1'b0, 2'b00, 3'b111, 0, -1, ab);  // NOP type

    // Reset during MEM_WAIT with counter=1
    do_instr(2'd0, 1'b0, 1'b0, 2'b10, 3'b000, 0, 1, ab);
    if (ab) begin
      cyc(M_NONE, 1'b0, "reset_hold");
      rst_a = 1'b0;
      cyc(M_NONE, 1'b0, "boot_after_reset");
    end else begin
      checks++;
      errors++;
      $error("FAIL abort_path observed=%0d expected=1", ab);
    end

    // Random instructions
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 15));
      op = (r == 0) ? 2'd2 : (r == 1) ? 2'd1 : (r == 2) ? 2'd3 : 2'd0;
      do_instr(op, ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
               3'($urandom), int'($urandom_range(0, 6)), -1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the CPU core.
- Steps every instruction through fetch, decode, execute and optional data-memory or rasterizer wait phases.
- Drives the decode unit's enable, the instruction latch, PC increment, register-file write enable and the rasterizer submit strobe.
- Consumes the registered decode outputs. Sits between the decode unit and the datapath, memory and rasterizer.

Parameters:
- MEM_LATENCY, 1, cycles a memory read/write occupies (instruction fetch and data access); legal range 1..15.

Ports:
- clk  in  1  core clock
- rst_async  in  1  asynchronous active-high reset
- inst_type  in  2  registered instruction type from decode
- inst_subtype  in  3  registered instruction subtype from decode
- core_special_op  in  core_special_operation_t  registered special op (CORE_NOP/CORE_HALT/CORE_RESET)
- gpu_submit  in  1  registered decode flag: current instruction is a rasterizer command
- gpu_busy  in  1  rasterizer busy
- resume  in  1  leave HALT (level, sampled each cycle)
- inst_latch_en  out  1  latch memory read data into instruction register
- decode_en  out  1  decode unit enable
- mem_access  out  1  memory port in use (fetch or data)
- mem_data_phase  out  1  current memory access is data, not instruction fetch
- pc_inc  out  1  increment PC this cycle
- rf_write_en  out  1  register-file write strobe
- gpu_submit_strobe  out  1  one-cycle rasterizer command submit
- soft_reset  out  1  one-cycle datapath reset pulse (PC/registers)
- halted  out  1  core in HALT

Behaviour:
- States: BOOT, FETCH, DECODE, EXECUTE, MEM_WAIT, GPU_WAIT, HALT. State register and a latency counter (4 bits) reset asynchronously to BOOT / 0.
- All outputs are combinational from state, counter and inputs. Every output is 0 while rst_async is high and in BOOT.
- BOOT: one cycle, no outputs asserted; go to FETCH.
- FETCH:
  - mem_access=1, mem_data_phase=0.
  - Counter increments each cycle. When counter==MEM_LATENCY-1: inst_latch_en=1, counter clears, go to DECODE.
  - Fetch occupies exactly MEM_LATENCY cycles.
- DECODE: decode_en=1 for exactly one cycle; go to EXECUTE. Decoded fields are valid from the first EXECUTE cycle.
- EXECUTE (one cycle). Priority order:
  1. core_special_op==CORE_RESET: soft_reset=1, no pc_inc; go to FETCH.
  2. core_special_op==CORE_HALT: pc_inc=1; go to HALT.
  3. gpu_submit=1:
     - gpu_busy=0: gpu_submit_strobe=1, pc_inc=1; go to FETCH.
     - gpu_busy=1: no strobe; go to GPU_WAIT.
  4. inst_type==2'b10 (data memory op): go to MEM_WAIT, counter=0.
  5. inst_type==2'b11, or inst_type==2'b01 with any subtype: rf_write_en=1, pc_inc=1; go to FETCH.
  6. Otherwise (type 00 NOP etc.): pc_inc=1; go to FETCH.
- MEM_WAIT:
  - mem_access=1, mem_data_phase=1.
  - On counter==MEM_LATENCY-1: rf_write_en=1, pc_inc=1, counter clears; go to FETCH.
- GPU_WAIT:
  - Hold while gpu_busy=1.
  - First cycle with gpu_busy=0: gpu_submit_strobe=1, pc_inc=1; go to FETCH.
  - Exactly one strobe per rasterizer instruction.
- HALT:
  - halted=1, all other outputs 0.
  - resume=1: go to FETCH next cycle; halted stays 1 during that cycle.
  - resume held high only leaves once; it has no effect in other states.
- pc_inc, rf_write_en, gpu_submit_strobe, soft_reset, inst_latch_en and decode_en are each at most one cycle wide per instruction.
- Reset mid-operation (any state, any counter value): immediate return to BOOT with all outputs 0. No strobe is emitted on or after release until the normal sequence resumes.
- Minimum instruction time is MEM_LATENCY+2 cycles (fetch, decode, execute).
- Unlisted enum values of core_special_op are treated as CORE_NOP.

Test Plan:
- Reset release, MEM_LATENCY=1, inst_type=01 subtype 010 (ADD) → cycles: BOOT, FETCH (inst_latch_en), DECODE (decode_en), EXECUTE (rf_write_en=1, pc_inc=1); repeats with period 3.
- MEM_LATENCY=3, inst_type=10 → FETCH mem_access for 3 cycles, DECODE 1, EXECUTE 1, MEM_WAIT 3 with mem_data_phase=1; rf_write_en and pc_inc in the 3rd MEM_WAIT cycle only.
- gpu_submit=1, gpu_busy=1 for 5 cycles then 0 → GPU_WAIT for 5 cycles, exactly one gpu_submit_strobe on the cycle gpu_busy reads 0, together with pc_inc.
- core_special_op=CORE_HALT, resume=0 for 10 cycles then 1 → pc_inc once in EXECUTE, halted=1 for 11 cycles, then FETCH.
- core_special_op=CORE_RESET → soft_reset=1 for one cycle, pc_inc=0, next state FETCH.
- Assert rst_async during MEM_WAIT with counter=1 (MEM_LATENCY=3) → all outputs 0 the same cycle, no rf_write_en; after release, BOOT then FETCH.
